mem_port_arbiter: RTL and testbench

Shares the single word-wide data-memory port between the CDM16 CPU bus and a secondary DMA/debug master, such as a loader or a GPU readback engine. The CPU owns the port by default. When the DMA master requests the port, the arbiter stalls the CPU through its hold input, drains one cycle, grants a bounded burst to the DMA master, and then returns the port to the CPU. The block sits between the CPU bus adapter (byte-lane split, word address) and the memory block RAM.

---
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the data-memory port between the CPU bus and a DMA/debug master.
// Optional burst fairness (bcnt + GAP state) is enabled by MEM_ARB_FAIRNESS_EN.
module mem_port_arbiter #(
   parameter int ADDR_W    = 15,
   parameter int DATA_W    = 16,
   parameter int MAX_BURST = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_en,
   input  logic [1:0]        cpu_write,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_hold,
   input  logic              dma_req,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic              dma_we,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   output logic              dma_rvalid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_out,
   output logic              mem_en,
   output logic [1:0]        mem_write,
   input  logic [DATA_W-1:0] mem_in
);

   if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
      $error("mem_port_arbiter: MAX_BURST must be in 1..15");
   end

   // Bit 1 of the encoding is exactly the hold condition, so cpu_hold
   // comes straight off a flop with no decode glitches.
`ifdef MEM_ARB_FAIRNESS_EN
   typedef enum logic [1:0] {
      CPU_OWN = 2'b00,
      GAP     = 2'b01,
      DRAIN   = 2'b10,
      DMA_OWN = 2'b11
   } state_e;
`else
   typedef enum logic [1:0] {
      CPU_OWN = 2'b00,
      DRAIN   = 2'b10,
      DMA_OWN = 2'b11
   } state_e;
`endif

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic              en;
      logic [1:0]        write;
   } mem_req_t;

   state_e   state_q, state_d;
   logic     rvalid_q, rvalid_d;
   logic     dma_sel;
   mem_req_t cpu_req, dma_req_s, mem_req;

`ifdef MEM_ARB_FAIRNESS_EN
   localparam logic [3:0] BCNT_LAST = 4'(MAX_BURST - 1);
   logic [3:0] bcnt_q, bcnt_d;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= CPU_OWN;
         rvalid_q <= 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
         bcnt_q   <= 4'd0;
`endif
      end else begin
         state_q  <= state_d;
         rvalid_q <= rvalid_d;
`ifdef MEM_ARB_FAIRNESS_EN
         bcnt_q   <= bcnt_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      dma_ack = 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
      bcnt_d  = bcnt_q;
`endif
      case (state_q)
         CPU_OWN: begin
            if (dma_req) state_d = DRAIN;
         end
         DRAIN: begin
            // CPU's in-flight access still owns the port this cycle.
`ifdef MEM_ARB_FAIRNESS_EN
            bcnt_d  = 4'd0;
`endif
            state_d = DMA_OWN;
         end
         DMA_OWN: begin
            dma_ack = dma_req;
            if (!dma_req) begin
               state_d = CPU_OWN;
            end else begin
`ifdef MEM_ARB_FAIRNESS_EN
               bcnt_d = bcnt_q + 4'd1;
               if (bcnt_q == BCNT_LAST) state_d = GAP;
`endif
            end
         end
`ifdef MEM_ARB_FAIRNESS_EN
         GAP: begin
            state_d = CPU_OWN;
         end
`endif
         default: state_d = CPU_OWN;
      endcase
   end

   assign cpu_hold = state_q[1];
   assign dma_sel  = (state_q == DMA_OWN);

   always_comb begin
      cpu_req.addr  = cpu_addr;
      cpu_req.wdata = cpu_wdata;
      cpu_req.en    = cpu_en;
      cpu_req.write = cpu_write;

      dma_req_s.addr  = dma_addr;
      dma_req_s.wdata = dma_wdata;
      dma_req_s.en    = dma_req;
      dma_req_s.write = {2{dma_req & dma_we}};

      mem_req = dma_sel ? dma_req_s : cpu_req;
   end

   assign mem_addr  = mem_req.addr;
   assign mem_out   = mem_req.wdata;
   assign mem_en    = mem_req.en;
   assign mem_write = mem_req.write;

   // Read return runs off the ack alone, so a read acked in the final
   // DMA_OWN cycle still completes after the port goes back to the CPU.
   assign rvalid_d   = dma_ack & ~dma_we;
   assign dma_rvalid = rvalid_q;
   assign dma_rdata  = rvalid_q ? mem_in : '0;
   assign cpu_rdata  = mem_in;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter; fairness tests follow MEM_ARB_FAIRNESS_EN.
module tb_mem_port_arbiter;
   localparam int AW = 15;
   localparam int DW = 16;
   localparam int MB = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] cpu_addr = '0;
   logic          cpu_en = 1'b0;
   logic [1:0]    cpu_write = 2'b00;
   logic [DW-1:0] cpu_wdata = '0;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_hold;
   logic          dma_req = 1'b0;
   logic [AW-1:0] dma_addr = '0;
   logic          dma_we = 1'b0;
   logic [DW-1:0] dma_wdata = '0;
   logic          dma_ack;
   logic [DW-1:0] dma_rdata;
   logic          dma_rvalid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_out;
   logic          mem_en;
   logic [1:0]    mem_write;
   logic [DW-1:0] mem_in = '0;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] sbq[$];
   logic [DW-1:0] sb_exp;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
      .clock(clock), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_en(cpu_en), .cpu_write(cpu_write),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
      .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we),
      .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
      .dma_rvalid(dma_rvalid), .mem_addr(mem_addr), .mem_out(mem_out),
      .mem_en(mem_en), .mem_write(mem_write), .mem_in(mem_in)
   );

   always #5 clock = ~clock;

   function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
      if (a == 15'h1234) return 16'hBEEF;
      return {a, 1'b0} ^ 16'hA55A;
   endfunction

   // RAM model: data one cycle after the address
   always @(posedge clock) mem_in <= rom(mem_addr);

   // Scoreboard: push on read ack, pop on rvalid
   always @(negedge clock) begin
      if (reset) begin
         sbq.delete();
      end else begin
         if (dma_rvalid) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL sb_rdata: unexpected rvalid, rdata=%h", dma_rdata);
            end else begin
               sb_exp = sbq.pop_front();
               if (dma_rdata !== sb_exp) begin
                  errors++;
                  $display("FAIL sb_rdata: got %h expected %h", dma_rdata, sb_exp);
               end
            end
         end
         if (dma_ack && !dma_we) sbq.push_back(rom(dma_addr));
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      #2;
      cpu_en = 1'b1; cpu_addr = 15'h0022;
      #1;
      checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL rst_hold: got %b expected 0", cpu_hold); end
      checks++; if (dma_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0", dma_ack); end
      checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b expected 0", dma_rvalid); end
      checks++; if (mem_en !== 1'b1 || mem_addr !== 15'h0022) begin errors++; $display("FAIL rst_passthru: got en=%b addr=%h expected en=1 addr=0022", mem_en, mem_addr); end
      step();
      reset = 1'b0;
   endtask

   task automatic test_passthrough();
      step();
      cpu_en = 1'b1; cpu_write = 2'b01; cpu_addr = 15'h0010; cpu_wdata = 16'h00AB;
      #1;
      checks++; if (mem_addr !== 15'h0010 || mem_out !== 16'h00AB) begin errors++; $display("FAIL pt_addr_data: got %h/%h expected 0010/00ab", mem_addr, mem_out); end
      checks++; if (mem_en !== 1'b1 || mem_write !== 2'b01) begin errors++; $display("FAIL pt_en_we: got %b/%b expected 1/01", mem_en, mem_write); end
      checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL pt_hold: got %b expected 0", cpu_hold); end
      step();
      cpu_write = 2'b10; cpu_addr = 15'h7FFF; cpu_wdata = 16'h5A00;
      #1;
      checks++; if (mem_write !== 2'b10 || mem_addr !== 15'h7FFF || mem_out !== 16'h5A00) begin errors++; $display("FAIL pt_hi_lane: got %b/%h/%h expected 10/7fff/5a00", mem_write, mem_addr, mem_out); end
      checks++; if (cpu_rdata !== rom(15'h0010)) begin errors++; $display("FAIL pt_rdata: got %h expected %h", cpu_rdata, rom(15'h0010)); end
      cpu_en = 1'b0;
      #1;
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL pt_en_off: got %b expected 0", mem_en); end
      // keep a busy CPU on the bus so DMA mux faults are visible
      cpu_en = 1'b1; cpu_write = 2'b11; cpu_addr = 15'h0555; cpu_wdata = 16'h1111;
   endtask

   task automatic test_single_read();
      step();
      dma_req = 1'b1; dma_addr = 15'h1234; dma_we = 1'b0; dma_wdata = 16'hFFFF;
      #1;
      checks++; if (cpu_hold !== 1'b0 || dma_ack !== 1'b0) begin errors++; $display("FAIL rd_req_cycle: got hold=%b ack=%b expected 0/0", cpu_hold, dma_ack); end
      step(); #1;
      checks++; if (cpu_hold !== 1'b1 || dma_ack !== 1'b0) begin errors++; $display("FAIL rd_drain: got hold=%b ack=%b expected 1/0", cpu_hold, dma_ack); end
      checks++; if (mem_addr !== 15'h0555 || mem_write !== 2'b11) begin errors++; $display("FAIL rd_drain_cpu: got %h/%b expected 0555/11", mem_addr, mem_write); end
      step(); #1;
      checks++; if (dma_ack !== 1'b1 || cpu_hold !== 1'b1) begin errors++; $display("FAIL rd_ack: got ack=%b hold=%b expected 1/1", dma_ack, cpu_hold); end
      checks++; if (mem_addr !== 15'h1234 || mem_en !== 1'b1 || mem_write !== 2'b00) begin errors++; $display("FAIL rd_mem: got %h/%b/%b expected 1234/1/00", mem_addr, mem_en, mem_write); end
      step();
      dma_req = 1'b0;
      #1;
      checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== 16'hBEEF) begin errors++; $display("FAIL rd_return: got %b/%h expected 1/beef", dma_rvalid, dma_rdata); end
      checks++; if (dma_ack !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL rd_idle: got ack=%b en=%b expected 0/0", dma_ack, mem_en); end
      step(); #1;
      checks++; if (cpu_hold !== 1'b0 || dma_rvalid !== 1'b0) begin errors++; $display("FAIL rd_release: got hold=%b rvalid=%b expected 0/0", cpu_hold, dma_rvalid); end
      checks++; if (mem_addr !== 15'h0555) begin errors++; $display("FAIL rd_back_cpu: got %h expected 0555", mem_addr); end
   endtask

   // Continuous request; every 2nd access of a 4 is a write, the 4th a read.
   task automatic test_continuous(input int cycles, input bit fair);
      int   nacc;
      logic saw_ack;
      nacc = 0;
      step();
      dma_req = 1'b1; dma_addr = 15'h0100; dma_we = 1'b0; dma_wdata = 16'hC000;
      for (int i = 0; i < cycles; i++) begin
         int   p;
         logic e_ack, e_hold;
         #1;
         if (fair) begin
            p = (i == 0) ? -1 : (i - 1) % 7;
            e_hold = (p >= 0 && p <= 4);
            e_ack  = (p >= 1 && p <= 4);
         end else begin
            p = -1;
            e_hold = (i >= 1);
            e_ack  = (i >= 2);
         end
         checks++; if (dma_ack !== e_ack || cpu_hold !== e_hold) begin errors++; $display("FAIL cont_%0d: cycle %0d got ack=%b hold=%b expected %b/%b", fair, i, dma_ack, cpu_hold, e_ack, e_hold); end
         if (fair && p == 5) begin
            checks++; if (dma_rvalid !== 1'b1) begin errors++; $display("FAIL gap_rvalid: cycle %0d got %b expected 1", i, dma_rvalid); end
         end
         if (dma_ack) begin
            checks++; if (mem_write !== {2{dma_we}} || mem_addr !== dma_addr || mem_out !== dma_wdata) begin errors++; $display("FAIL cont_mem: cycle %0d got %b/%h/%h expected %b/%h/%h", i, mem_write, mem_addr, mem_out, {2{dma_we}}, dma_addr, dma_wdata); end
         end
         saw_ack = dma_ack;
         step();
         if (saw_ack) begin
            nacc++;
            dma_addr  = dma_addr + 15'd1;
            dma_wdata = dma_wdata + 16'd1;
            dma_we    = (nacc % 4 == 1);
         end
      end
      dma_req = 1'b0; dma_we = 1'b0;
      #1;
      checks++; if (dma_ack !== 1'b0 || cpu_hold !== 1'b1) begin errors++; $display("FAIL cont_drop: got ack=%b hold=%b expected 0/1", dma_ack, cpu_hold); end
      step(); #1;
      checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL cont_release: got %b expected 0", cpu_hold); end
      step();
   endtask

   task automatic test_reset_mid_burst();
      step();
      dma_req = 1'b1; dma_addr = 15'h0200; dma_we = 1'b0;
      step();
      step(); #1;
      checks++; if (dma_ack !== 1'b1) begin errors++; $display("FAIL mid_ack1: got %b expected 1", dma_ack); end
      step();
      dma_addr = 15'h0201;
      #1;
      checks++; if (dma_ack !== 1'b1 || dma_rvalid !== 1'b1) begin errors++; $display("FAIL mid_ack2: got ack=%b rvalid=%b expected 1/1", dma_ack, dma_rvalid); end
      reset = 1'b1; dma_req = 1'b0;
      #1;
      checks++; if (cpu_hold !== 1'b0 || dma_ack !== 1'b0 || dma_rvalid !== 1'b0) begin errors++; $display("FAIL mid_reset: got hold=%b ack=%b rvalid=%b expected 0/0/0", cpu_hold, dma_ack, dma_rvalid); end
      checks++; if (mem_addr !== 15'h0555 || mem_en !== 1'b1) begin errors++; $display("FAIL mid_reset_mux: got %h/%b expected 0555/1", mem_addr, mem_en); end
      step();
      reset = 1'b0;
      #1;
      checks++; if (cpu_hold !== 1'b0 || dma_rvalid !== 1'b0) begin errors++; $display("FAIL mid_post: got hold=%b rvalid=%b expected 0/0", cpu_hold, dma_rvalid); end
      dma_req = 1'b1; dma_addr = 15'h0300;
      step(); #1;
      checks++; if (cpu_hold !== 1'b1 || dma_ack !== 1'b0) begin errors++; $display("FAIL mid_drain: got hold=%b ack=%b expected 1/0", cpu_hold, dma_ack); end
      step(); #1;
      checks++; if (dma_ack !== 1'b1 || mem_addr !== 15'h0300) begin errors++; $display("FAIL mid_regrant: got ack=%b addr=%h expected 1/0300", dma_ack, mem_addr); end
      step();
      dma_req = 1'b0;
      #1;
      checks++; if (dma_rvalid !== 1'b1) begin errors++; $display("FAIL mid_rvalid: got %b expected 1", dma_rvalid); end
      step(); #1;
      checks++; if (cpu_hold !== 1'b0) begin errors++; $display("FAIL mid_release: got %b expected 0", cpu_hold); end
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_single_read();
`ifdef MEM_ARB_FAIRNESS_EN
      test_continuous(17, 1'b1);
`else
      test_continuous(12, 1'b0);
`endif
      test_reset_mid_burst();
      step(); step();
      checks++;
      if (sbq.size() != 0) begin errors++; $display("FAIL sb_drain: %0d reads never returned, expected 0", sbq.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
